// File: rtl/bht_update_queue.sv
// bht_update_queue: FIFO of resolved branch outcomes drained one per cycle into the BHT update port (optional same-cycle bypass via BHT_UPD_BYPASS_EN)
module bht_update_queue #(
  parameter int unsigned VLEN     = 64,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned IDX_BITS = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_bp_i,
  input  logic                         debug_mode_i,
  input  logic                         upd_valid_i,
  input  logic [VLEN-1:0]              upd_pc_i,
  input  logic [IDX_BITS-1:0]          upd_index_i,
  input  logic                         upd_taken_i,
  output logic                         upd_ready_o,
  input  logic                         bht_stall_i,
  output logic                         bht_valid_o,
  output logic [VLEN-1:0]              bht_pc_o,
  output logic [IDX_BITS-1:0]          bht_index_o,
  output logic                         bht_taken_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic [15:0]                  drop_cnt_o
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);
  logic [VLEN-1:0]     pc_mem_q    [DEPTH];
  logic [IDX_BITS-1:0] idx_mem_q   [DEPTH];
  logic                taken_mem_q [DEPTH];
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic [15:0]         drop_q, drop_d;
  logic                accept, full, pop, push, drop, bypass;
  // Handshake, bypass selection, head mux and next-state pointer/count math
  always_comb begin
    accept      = upd_valid_i && !debug_mode_i && !flush_bp_i;
    full        = count_q == CW'(DEPTH);
    pop         = count_q != '0 && !bht_stall_i && !debug_mode_i && !flush_bp_i;
`ifdef BHT_UPD_BYPASS_EN
    bypass      = accept && count_q == '0 && !bht_stall_i;
`else
    bypass      = 1'b0;
`endif
    push        = accept && !bypass && (!full || pop);
    drop        = accept && full && !pop;
    upd_ready_o = !full || pop;
    bht_valid_o = pop || bypass;
    bht_pc_o    = bypass ? upd_pc_i    : pc_mem_q[rd_ptr_q];
    bht_index_o = bypass ? upd_index_i : idx_mem_q[rd_ptr_q];
    bht_taken_o = bypass ? upd_taken_i : taken_mem_q[rd_ptr_q];
    wr_ptr_d    = flush_bp_i ? '0 : wr_ptr_q + PW'(push);
    rd_ptr_d    = flush_bp_i ? '0 : rd_ptr_q + PW'(pop);
    count_d     = flush_bp_i ? '0 : count_q + CW'(push) - CW'(pop);
    drop_d      = (drop && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
  end
  // Control state; reset wins over flush, push and pop
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      drop_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      drop_q   <= drop_d;
    end
  end
  // Entry storage is never reset; only count decides which entries are live
  always_ff @(posedge clk_i) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]    <= upd_pc_i;
      idx_mem_q[wr_ptr_q]   <= upd_index_i;
      taken_mem_q[wr_ptr_q] <= upd_taken_i;
    end
  end
  assign count_o    = count_q;
  assign drop_cnt_o = drop_q;
endmodule

// File: tb/tb_bht_update_queue.sv
// tb_bht_update_queue: directed self-checking bench for bht_update_queue
module tb_bht_update_queue;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        debug = 1'b0;
  logic        upd_valid = 1'b0;
  logic [63:0] upd_pc = '0;
  logic [7:0]  upd_index = '0;
  logic        upd_taken = 1'b0;
  logic        upd_ready;
  logic        stall = 1'b0;
  logic        bht_valid;
  logic [63:0] bht_pc;
  logic [7:0]  bht_index;
  logic        bht_taken;
  logic [2:0]  count;
  logic [15:0] drop_cnt;
  int checks = 0;
  int errors = 0;

  bht_update_queue #(.VLEN(64), .DEPTH(4), .IDX_BITS(8)) dut (
    .clk_i(clk), .rst_i(rst), .flush_bp_i(flush), .debug_mode_i(debug),
    .upd_valid_i(upd_valid), .upd_pc_i(upd_pc), .upd_index_i(upd_index),
    .upd_taken_i(upd_taken), .upd_ready_o(upd_ready), .bht_stall_i(stall),
    .bht_valid_o(bht_valid), .bht_pc_o(bht_pc), .bht_index_o(bht_index),
    .bht_taken_o(bht_taken), .count_o(count), .drop_cnt_o(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_pc(input logic [63:0] pc);
    upd_valid = 1'b1;
    upd_pc = pc;
    upd_index = pc[9:2];
    upd_taken = pc[2];
    step();
  endtask

  initial begin
    step();
    step();
    rst = 1'b0;
    chk("rst_count", count, 0);
    chk("rst_valid", bht_valid, 0);
    chk("rst_ready", upd_ready, 1);
    chk("rst_drop", drop_cnt, 0);
    // single update
    upd_valid = 1'b1; upd_pc = 64'h8000_0010; upd_index = 8'h04; upd_taken = 1'b1;
    #1;
`ifndef BHT_UPD_BYPASS_EN
    chk("single_no_bypass", bht_valid, 0);
`endif
    step();
    upd_valid = 1'b0;
    #1;
`ifndef BHT_UPD_BYPASS_EN
    chk("single_count", count, 1);
    chk("single_valid", bht_valid, 1);
    chk("single_pc", bht_pc, 64'h8000_0010);
    chk("single_idx", bht_index, 8'h04);
    chk("single_taken", bht_taken, 1);
    step();
`endif
    chk("single_drained", count, 0);
    chk("single_idle", bht_valid, 0);
    // stalled overflow
    stall = 1'b1;
    for (int i = 0; i < 6; i++) push_pc(64'h100 + 64'(4 * i));
    upd_valid = 1'b0;
    #1;
    chk("ovf_count", count, 4);
    chk("ovf_drop", drop_cnt, 2);
    chk("ovf_ready", upd_ready, 0);
    chk("ovf_head_stable", bht_pc, 64'h100);
    chk("ovf_valid_stalled", bht_valid, 0);
    stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("ovf_pop_valid", bht_valid, 1);
      chk("ovf_pop_pc", bht_pc, 64'h100 + 64'(4 * i));
      step();
    end
    chk("ovf_empty", count, 0);
    // full queue streaming
    stall = 1'b1;
    for (int i = 0; i < 4; i++) push_pc(64'h200 + 64'(4 * i));
    stall = 1'b0;
    for (int k = 0; k < 10; k++) begin
      upd_valid = 1'b1; upd_pc = 64'h210 + 64'(4 * k);
      #1;
      chk("stream_ready", upd_ready, 1);
      chk("stream_pc", bht_pc, 64'h200 + 64'(4 * k));
      step();
      chk("stream_count", count, 4);
    end
    upd_valid = 1'b0;
    chk("stream_drop", drop_cnt, 2);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("stream_tail_pc", bht_pc, 64'h228 + 64'(4 * i));
      step();
    end
    chk("stream_empty", count, 0);
    // flush
    stall = 1'b1;
    for (int i = 0; i < 3; i++) push_pc(64'h300 + 64'(4 * i));
    chk("flush_pre_count", count, 3);
    stall = 1'b0; flush = 1'b1; upd_valid = 1'b1; upd_pc = 64'h3F0;
    #1;
    chk("flush_no_pop", bht_valid, 0);
    step();
    flush = 1'b0; upd_valid = 1'b0;
    #1;
    chk("flush_count", count, 0);
    chk("flush_valid", bht_valid, 0);
    chk("flush_drop", drop_cnt, 2);
    // debug mode
    stall = 1'b1;
    push_pc(64'h400);
    push_pc(64'h404);
    stall = 1'b0; debug = 1'b1; upd_valid = 1'b1; upd_pc = 64'h500;
    #1;
    chk("dbg_no_valid", bht_valid, 0);
    step();
    step();
    chk("dbg_count", count, 2);
    chk("dbg_drop", drop_cnt, 2);
    debug = 1'b0; upd_valid = 1'b0;
    #1;
    chk("dbg_pop0", bht_pc, 64'h400);
    step();
    chk("dbg_pop1", bht_pc, 64'h404);
    step();
    chk("dbg_empty", count, 0);
    // bypass behaviour on an empty, unstalled queue
    upd_valid = 1'b1; upd_pc = 64'h600; upd_index = 8'h3F; upd_taken = 1'b0;
    #1;
`ifdef BHT_UPD_BYPASS_EN
    chk("byp_valid", bht_valid, 1);
    chk("byp_idx", bht_index, 8'h3F);
    chk("byp_taken", bht_taken, 0);
    step();
    upd_valid = 1'b0;
    chk("byp_count", count, 0);
`else
    chk("nobyp_valid", bht_valid, 0);
    step();
    upd_valid = 1'b0;
    chk("nobyp_count", count, 1);
    chk("nobyp_idx", bht_index, 8'h3F);
    chk("nobyp_taken", bht_taken, 0);
    step();
    chk("nobyp_empty", count, 0);
`endif
    // reset mid-operation
    stall = 1'b1;
    push_pc(64'h700);
    push_pc(64'h704);
    rst = 1'b1;
    push_pc(64'h708);
    rst = 1'b0; upd_valid = 1'b0; stall = 1'b0;
    #1;
    chk("mrst_count", count, 0);
    chk("mrst_valid", bht_valid, 0);
    chk("mrst_ready", upd_ready, 1);
    chk("mrst_drop", drop_cnt, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
